sc_sng_bank: RTL

//  Parallel stochastic number generator bank: the transmit end of the SC

---
 rtl/sc_sng_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sc_sng_bank.sv
// Parallel stochastic number generator bank: N lanes share one Fibonacci LFSR.
// Each lane compares its own rotation of the LFSR against its operand.

module sc_sng_lane #(
    parameter int B   = 8,
    parameter int ROT = 0
) (
    input  logic [B-1:0] lfsr_i,
    input  logic [B-1:0] value_i,
    input  logic         en_i,
    output logic         bit_o
);
    logic [B-1:0] rot;

    // Each lane sees a different rotation, which decorrelates lanes that
    // share the single LFSR.
    generate
        if (ROT == 0) begin : g_norot
            assign rot = lfsr_i;
        end else begin : g_rot
            assign rot = {lfsr_i[B-1-ROT:0], lfsr_i[B-1:B-ROT]};
        end
    endgenerate

    assign bit_o = en_i & (rot < value_i);
endmodule

module sc_sng_bank #(
    parameter int K = 3,
    parameter int N = 2**K,
    parameter int B = 8,
    parameter int L = 256,
    parameter logic [B-1:0] TAPS = B'(8'hB8)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [N*B-1:0]       values,
    input  logic [B-1:0]         seed,
    input  logic                 start,
    input  logic                 abort,
    output logic [N-1:0]         dout,
    output logic                 valid,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(L)-1:0] bit_idx
);
    localparam int IW = $clog2(L);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [B-1:0]            lfsr_q, lfsr_d;
    logic [N-1:0][B-1:0]     val_q, val_d;

    // Shift left, feedback is the XOR of the tapped bits (x^B term is the MSB).
    function automatic logic [B-1:0] lfsr_step(input logic [B-1:0] s);
        return {s[B-2:0], ^(s & TAPS)};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lfsr_q  <= B'(1);
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        val_d   = val_q;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        val_d  = values;
                        lfsr_d = (seed == '0) ? B'(1) : seed;
                    end
                    if (start) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                    end
                end
                S_RUN: begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (idx_q == IW'(L-1))
                        state_d = S_DONE;
                    else
                        idx_d = idx_q + 1'b1;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign busy    = (state_q == S_RUN);
    assign valid   = busy;
    assign done    = (state_q == S_DONE);
    assign bit_idx = idx_q;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            sc_sng_lane #(.B(B), .ROT(i)) u_lane (
                .lfsr_i  (lfsr_q),
                .value_i (val_q[i]),
                .en_i    (busy),
                .bit_o   (dout[i])
            );
        end
    endgenerate
endmodule
